// File: rtl/blink_pkg.sv
// Shared definitions for the blink-light sequencer: state encoding and default widths.
package blink_pkg;

    localparam int CNT_W_DEF    = 16;
    localparam int REP_W_DEF    = 8;
    localparam int REPS_FOREVER = 0;

    // 2'd3 is unused; the sequencer treats it as IDLE with the LED off.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2
    } state_e;

endpackage

// File: rtl/blink_sequencer_phase_counter.sv
// Down counter timing one LED phase; flags expiry when the count reads 1.
module phase_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         expire
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire = (count_q == W'(1));

endmodule

// File: rtl/blink_sequencer.sv
// Blink-light sequencer: runs on/off LED phases for a finite or continuous
// number of repeats, with registered led/busy/done outputs.
module blink_sequencer
    import blink_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int REP_W = REP_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [CNT_W-1:0] on_len,
    input  logic [CNT_W-1:0] off_len,
    input  logic [REP_W-1:0] reps,
    output logic             led,
    output logic             busy,
    output logic             done
);

    state_e           state_q, state_d;
    logic             led_q, led_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] eff_on_q, eff_on_d;
    logic [CNT_W-1:0] eff_off_q, eff_off_d;
    logic [REP_W-1:0] rep_q, rep_d;
    logic             forever_q, forever_d;

    logic             phase_load;
    logic [CNT_W-1:0] phase_load_val;
    logic             phase_dec;
    logic             phase_expire;

    // A zero-length phase still lasts one cycle.
    function automatic logic [CNT_W-1:0] eff_len(input logic [CNT_W-1:0] len);
        return (len == '0) ? CNT_W'(1) : len;
    endfunction

    phase_counter #(
        .W (CNT_W)
    ) u_phase_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (phase_load),
        .load_val (phase_load_val),
        .dec      (phase_dec),
        .expire   (phase_expire)
    );

    always_comb begin
        state_d        = state_q;
        led_d          = led_q;
        busy_d         = busy_q;
        done_d         = 1'b0;
        eff_on_d       = eff_on_q;
        eff_off_d      = eff_off_q;
        rep_d          = rep_q;
        forever_d      = forever_q;
        phase_load     = 1'b0;
        phase_load_val = '0;
        phase_dec      = 1'b0;

        case (state_q)
            IDLE: begin
                led_d  = 1'b0;
                busy_d = 1'b0;
                if (start && !stop) begin
                    state_d        = ON;
                    led_d          = 1'b1;
                    busy_d         = 1'b1;
                    eff_on_d       = eff_len(on_len);
                    eff_off_d      = eff_len(off_len);
                    rep_d          = reps;
                    forever_d      = (reps == REP_W'(REPS_FOREVER));
                    phase_load     = 1'b1;
                    phase_load_val = eff_len(on_len);
                end
            end

            ON: begin
                if (stop) begin
                    state_d    = IDLE;
                    led_d      = 1'b0;
                    busy_d     = 1'b0;
                    rep_d      = '0;
                    phase_load = 1'b1;
                end else if (phase_expire) begin
                    state_d        = OFF;
                    led_d          = 1'b0;
                    phase_load     = 1'b1;
                    phase_load_val = eff_off_q;
                end else begin
                    phase_dec = 1'b1;
                end
            end

            OFF: begin
                if (stop) begin
                    state_d    = IDLE;
                    led_d      = 1'b0;
                    busy_d     = 1'b0;
                    rep_d      = '0;
                    phase_load = 1'b1;
                end else if (phase_expire) begin
                    if (forever_q || (rep_q > REP_W'(1))) begin
                        state_d        = ON;
                        led_d          = 1'b1;
                        phase_load     = 1'b1;
                        phase_load_val = eff_on_q;
                        if (!forever_q) begin
                            rep_d = rep_q - REP_W'(1);
                        end
                    end else begin
                        state_d    = IDLE;
                        led_d      = 1'b0;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                        rep_d      = '0;
                        phase_load = 1'b1;
                    end
                end else begin
                    phase_dec = 1'b1;
                end
            end

            default: begin
                state_d    = IDLE;
                led_d      = 1'b0;
                busy_d     = 1'b0;
                rep_d      = '0;
                phase_load = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            led_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            eff_on_q  <= '0;
            eff_off_q <= '0;
            rep_q     <= '0;
            forever_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            led_q     <= led_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            eff_on_q  <= eff_on_d;
            eff_off_q <= eff_off_d;
            rep_q     <= rep_d;
            forever_q <= forever_d;
        end
    end

    assign led  = led_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_blink_sequencer.sv
// Self-checking bench for blink_sequencer: directed scenarios plus random
// start/stop traffic against an elapsed-time model of the blink pattern.
module tb_blink_sequencer;

    localparam int CNT_W = 16;
    localparam int REP_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic [CNT_W-1:0] on_len = '0;
    logic [CNT_W-1:0] off_len = '0;
    logic [REP_W-1:0] reps = '0;
    logic             led;
    logic             busy;
    logic             done;

    int errors = 0;
    int checks = 0;

    // Model: pattern described only by time elapsed since the accepted start.
    bit m_active = 1'b0;
    bit m_done   = 1'b0;
    int m_t      = 0;
    int m_on     = 1;
    int m_off    = 1;
    int m_reps   = 0;

    always #5 clk = ~clk;

    blink_sequencer #(
        .CNT_W (CNT_W),
        .REP_W (REP_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .stop    (stop),
        .on_len  (on_len),
        .off_len (off_len),
        .reps    (reps),
        .led     (led),
        .busy    (busy),
        .done    (done)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        m_done   = 1'b0;
        m_t      = 0;
    endtask

    task automatic model_edge();
        if (rst) begin
            model_reset();
        end else begin
            m_done = 1'b0;
            if (m_active) begin
                if (stop) begin
                    m_active = 1'b0;
                end else begin
                    m_t++;
                    if (m_reps != 0 && m_t == m_reps * (m_on + m_off)) begin
                        m_active = 1'b0;
                        m_done   = 1'b1;
                    end
                end
            end else if (start && !stop) begin
                m_active = 1'b1;
                m_t      = 0;
                m_on     = (on_len == '0) ? 1 : int'(on_len);
                m_off    = (off_len == '0) ? 1 : int'(off_len);
                m_reps   = int'(reps);
                $display("pattern start on=%0d off=%0d reps=%0d at %0t", on_len, off_len, reps, $time);
            end
        end
    endtask

    task automatic check_outputs(input string ctx);
        logic exp_led;
        exp_led = m_active && ((m_t % (m_on + m_off)) < m_on);
        check_eq({ctx, ".led"}, led, exp_led);
        check_eq({ctx, ".busy"}, busy, m_active);
        check_eq({ctx, ".done"}, done, m_done);
    endtask

    task automatic tick(input string ctx);
        @(posedge clk);
        model_edge();
        #1;
        check_outputs(ctx);
    endtask

    task automatic drive(input bit s, input bit p, input int on_v, input int off_v, input int r);
        start   = s;
        stop    = p;
        on_len  = CNT_W'(on_v);
        off_len = CNT_W'(off_v);
        reps    = REP_W'(r);
    endtask

    initial begin
        // Reset state, observed without any clock edge.
        #1;
        check_eq("reset.led", led, 1'b0);
        check_eq("reset.busy", busy, 1'b0);
        check_eq("reset.done", done, 1'b0);
        tick("reset");
        tick("reset");
        rst = 1'b0;
        tick("idle");

        // Finite 3/2 x2, with an ignored start (on_len=9) mid-pattern.
        drive(1, 0, 3, 2, 2);
        tick("finite");
        drive(0, 0, 0, 0, 0);
        repeat (3) tick("finite");
        drive(1, 0, 9, 9, 1);
        tick("finite_busy_start");
        drive(0, 0, 0, 0, 0);
        repeat (8) tick("finite");

        // Zero lengths behave as one cycle each.
        drive(1, 0, 0, 0, 3);
        tick("zero");
        drive(0, 0, 0, 0, 0);
        repeat (8) tick("zero");

        // Continuous mode, stopped during an ON phase.
        drive(1, 0, 4, 4, 0);
        tick("cont");
        drive(0, 0, 0, 0, 0);
        repeat (40) tick("cont");
        check_eq("cont.on_before_stop", led, 1'b1);
        drive(0, 1, 0, 0, 0);
        tick("cont_stop");
        drive(0, 0, 0, 0, 0);
        repeat (4) tick("cont_after");

        // Start and stop together in IDLE: stop wins.
        drive(1, 1, 2, 2, 1);
        tick("start_stop");
        drive(0, 0, 0, 0, 0);
        repeat (2) tick("start_stop");

        // Asynchronous reset between edges during OFF.
        drive(1, 0, 3, 3, 2);
        tick("areset");
        drive(0, 0, 0, 0, 0);
        repeat (4) tick("areset");
        check_eq("areset.in_off", led, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_eq("areset.led_now", led, 1'b0);
        check_eq("areset.busy_now", busy, 1'b0);
        check_eq("areset.done_now", done, 1'b0);
        model_reset();
        tick("areset_hold");
        rst = 1'b0;
        drive(1, 0, 2, 2, 1);
        tick("areset_restart");
        check_eq("areset.led_k1", led, 1'b1);
        drive(0, 0, 0, 0, 0);

        // Back-to-back: new start while done is high.
        begin
            int budget;
            budget = 0;
            while (!m_done && budget < 40) begin
                tick("b2b_wait");
                budget++;
            end
            check_eq("b2b.done_seen", done, 1'b1);
            drive(1, 0, 2, 1, 1);
            tick("b2b_start");
            check_eq("b2b.led_next", led, 1'b1);
            drive(0, 0, 0, 0, 0);
            repeat (5) tick("b2b");
        end

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 7) == 0), ($urandom_range(0, 49) == 0),
                  $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 3));
            tick("rand");
        end
        drive(0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
